// File: rtl/cache_controller_2way_if.sv
// Bus bundle between MEM stage, cache and SRAM controller.
// master drives requests and SRAM responses; slave is the cache.
interface cache_controller_2way_if;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] address;
    logic [31:0] wdata;
    logic        sram_ready;
    logic [63:0] sram_rdata;
    logic        ready;
    logic [31:0] rdata;
    logic [31:0] sram_address;
    logic [31:0] sram_wdata;
    logic        write;
    logic        read;

    modport master (
        output MEM_R_EN, MEM_W_EN, address, wdata,
        output sram_ready, sram_rdata,
        input  ready, rdata, sram_address, sram_wdata,
        input  write, read
    );

    modport slave (
        input  MEM_R_EN, MEM_W_EN, address, wdata,
        input  sram_ready, sram_rdata,
        output ready, rdata, sram_address, sram_wdata,
        output write, read
    );
endinterface

// File: rtl/cache_controller_2way.sv
// Two-way set-associative write-through, no-write-allocate cache.
// Define CACHE_WRITE_UPDATE_EN to update write hits in place.
module cache_controller_2way #(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 9
) (
    input logic                    clk,
    input logic                    rst,
    cache_controller_2way_if.slave bus
);
    localparam int SETS = 1 << INDEX_W;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_MISS = 2'd1;
    localparam logic [1:0] WR      = 2'd2;

    logic [1:0]       r_state;
    logic             r_read;
    logic             r_write;
    logic [31:0]      r_sram_address;
    logic [31:0]      r_sram_wdata;
    logic [SETS-1:0]  r_valid0;
    logic [SETS-1:0]  r_valid1;
    logic [SETS-1:0]  r_lru;
    logic [TAG_W-1:0] r_tag0 [SETS];
    logic [TAG_W-1:0] r_tag1 [SETS];
    logic [63:0]      r_data0 [SETS];
    logic [63:0]      r_data1 [SETS];

    logic [INDEX_W-1:0] w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic               w_sel;
    logic               w_hit0;
    logic               w_hit1;
    logic               w_hit;
    logic [63:0]        w_hit_line;
    logic [31:0]        w_hit_word;
    logic               w_wr_req;
    logic               w_rd_req;
    logic [INDEX_W-1:0] w_f_idx;
    logic [TAG_W-1:0]   w_f_tag;
    logic               w_victim;
    logic               w_fill;
    logic [31:0]        w_fill_word;
    logic               w_unused;

    assign w_idx      = bus.address[INDEX_W+2:3];
    assign w_tag      = bus.address[TAG_W+INDEX_W+2:INDEX_W+3];
    assign w_sel      = bus.address[2];
    assign w_hit0     = r_valid0[w_idx] && (r_tag0[w_idx] == w_tag);
    assign w_hit1     = r_valid1[w_idx] && (r_tag1[w_idx] == w_tag);
    assign w_hit      = w_hit0 | w_hit1;
    assign w_hit_line = w_hit0 ? r_data0[w_idx] : r_data1[w_idx];
    assign w_hit_word = w_sel ? w_hit_line[63:32] : w_hit_line[31:0];
    assign w_wr_req   = bus.MEM_W_EN;
    assign w_rd_req   = bus.MEM_R_EN & ~bus.MEM_W_EN;

    // Fill side works from the latched address so a dropped request still fills.
    assign w_f_idx     = r_sram_address[INDEX_W+2:3];
    assign w_f_tag     = r_sram_address[TAG_W+INDEX_W+2:INDEX_W+3];
    assign w_victim    = !r_valid0[w_f_idx] ? 1'b0 :
                         !r_valid1[w_f_idx] ? 1'b1 : r_lru[w_f_idx];
    assign w_fill      = (r_state == RD_MISS) && bus.sram_ready;
    assign w_fill_word = r_sram_address[2] ? bus.sram_rdata[63:32]
                                           : bus.sram_rdata[31:0];

    assign w_unused = ^{bus.address[31:TAG_W+INDEX_W+3], bus.address[1:0]};

    assign bus.read         = r_read;
    assign bus.write        = r_write;
    assign bus.sram_address = r_sram_address;
    assign bus.sram_wdata   = r_sram_wdata;

    // Pipeline handshake: hits answer in the same cycle, SRAM completions pass through.
    always_comb begin
        bus.ready = 1'b0;
        bus.rdata = 32'd0;
        case (r_state)
            IDLE: begin
                if (!w_wr_req && !bus.MEM_R_EN) begin
                    bus.ready = 1'b1;
                end else if (w_rd_req && w_hit) begin
                    bus.ready = 1'b1;
                    bus.rdata = w_hit_word;
                end
            end
            RD_MISS: begin
                if (bus.sram_ready) begin
                    bus.ready = 1'b1;
                    bus.rdata = w_fill_word;
                end
            end
            WR: begin
                bus.ready = bus.sram_ready;
            end
            default: begin
                bus.ready = 1'b0;
            end
        endcase
    end

    // FSM and SRAM request registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_read         <= 1'b0;
            r_write        <= 1'b0;
            r_sram_address <= 32'd0;
            r_sram_wdata   <= 32'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_wr_req) begin
                        r_sram_address <= bus.address;
                        r_sram_wdata   <= bus.wdata;
                        r_write        <= 1'b1;
                        r_state        <= WR;
                    end else if (w_rd_req && !w_hit) begin
                        r_sram_address <= bus.address;
                        r_read         <= 1'b1;
                        r_state        <= RD_MISS;
                    end
                end
                RD_MISS: begin
                    if (bus.sram_ready) begin
                        r_read  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                WR: begin
                    if (bus.sram_ready) begin
                        r_write <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Valid and LRU bookkeeping: fills, read-hit recency and write-hit invalidation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid0 <= '0;
            r_valid1 <= '0;
            r_lru    <= '0;
        end else if (w_fill) begin
            if (w_victim) r_valid1[w_f_idx] <= 1'b1;
            else          r_valid0[w_f_idx] <= 1'b1;
            r_lru[w_f_idx] <= ~w_victim;
        end else if (r_state == IDLE) begin
            if (w_rd_req && w_hit) begin
                r_lru[w_idx] <= w_hit0;
            end
`ifndef CACHE_WRITE_UPDATE_EN
            if (w_wr_req && w_hit0) r_valid0[w_idx] <= 1'b0;
            if (w_wr_req && w_hit1) r_valid1[w_idx] <= 1'b0;
`endif
        end
    end

    // Tag and data arrays: line fills and, when enabled, in-place write hits.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            if (w_victim) begin
                r_tag1[w_f_idx]  <= w_f_tag;
                r_data1[w_f_idx] <= bus.sram_rdata;
            end else begin
                r_tag0[w_f_idx]  <= w_f_tag;
                r_data0[w_f_idx] <= bus.sram_rdata;
            end
        end
`ifdef CACHE_WRITE_UPDATE_EN
        else if (r_state == IDLE && w_wr_req) begin
            if (w_hit0) begin
                if (w_sel) r_data0[w_idx][63:32] <= bus.wdata;
                else       r_data0[w_idx][31:0]  <= bus.wdata;
            end else if (w_hit1) begin
                if (w_sel) r_data1[w_idx][63:32] <= bus.wdata;
                else       r_data1[w_idx][31:0]  <= bus.wdata;
            end
        end
`endif
    end
endmodule
